// File: rtl/rio_packet_checker.sv
// RX packet checker: per-beat data check against a running counter, per-packet length check
// against an 8-bit LFSR, SOP/EOP framing check. Optional macro RIO_PKT_CHK_RESYNC_EN enables resync.
module rio_packet_checker #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    CNT_WIDTH  = 20,
  parameter logic [7:0]            LFSR_SEED  = 8'h05,
  parameter logic [DATA_WIDTH-1:0] DATA_SEED  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_rx_valid,
  input  logic                  i_rx_sop,
  input  logic                  i_rx_eop,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  output logic [CNT_WIDTH-1:0]  o_data_err_cnt,
  output logic [CNT_WIDTH-1:0]  o_size_err_cnt,
  output logic [CNT_WIDTH-1:0]  o_frame_err_cnt,
  output logic [CNT_WIDTH-1:0]  o_pkt_cnt,
  output logic                  o_rx_data_error,
  output logic                  o_rx_size_error,
  output logic                  o_rx_frame_error
);

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [7:0]            lfsr_q, lfsr_d;
  logic [7:0]            wcnt_q, wcnt_d;
  logic [DATA_WIDTH-1:0] dcnt_q, dcnt_d;
  logic [CNT_WIDTH-1:0]  data_err_cnt_q, data_err_cnt_d;
  logic [CNT_WIDTH-1:0]  size_err_cnt_q, size_err_cnt_d;
  logic [CNT_WIDTH-1:0]  frame_err_cnt_q, frame_err_cnt_d;
  logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic                  data_flag_q, data_flag_d;
  logic                  size_flag_q, size_flag_d;
  logic                  frame_flag_q, frame_flag_d;

  logic       beat;
  logic       sop;
  logic       eop;
  logic       data_err;
  logic       frame_err;
  logic       size_chk;
  logic       size_err;
  logic [7:0] size_wcnt;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic en);
    logic [CNT_WIDTH-1:0] r;
    r = v;
    if (en && (v != {CNT_WIDTH{1'b1}})) begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  assign beat = i_rx_valid;
  assign sop  = i_rx_valid & i_rx_sop;
  assign eop  = i_rx_valid & i_rx_eop;

  // Framing FSM: wcnt counts beats before the eop beat; a sop always starts a fresh packet.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    frame_err = 1'b0;
    size_chk  = 1'b0;
    size_wcnt = wcnt_q;
    if (beat) begin
      case (state_q)
        IDLE: begin
          if (sop) begin
            if (eop) begin
              size_chk  = 1'b1;
              size_wcnt = 8'h00;
              wcnt_d    = 8'h00;
            end else begin
              state_d = DATA;
              wcnt_d  = 8'h01;
            end
          end else begin
            frame_err = 1'b1;
          end
        end
        DATA: begin
          if (sop) begin
            frame_err = 1'b1;
            if (eop) begin
              size_chk  = 1'b1;
              size_wcnt = 8'h00;
              wcnt_d    = 8'h00;
              state_d   = IDLE;
            end else begin
              wcnt_d = 8'h01;
            end
          end else if (eop) begin
            size_chk  = 1'b1;
            size_wcnt = wcnt_q;
            wcnt_d    = 8'h00;
            state_d   = IDLE;
          end else if (wcnt_q != 8'hFF) begin
            wcnt_d = wcnt_q + 8'h01;
          end
        end
        default: begin
          state_d = IDLE;
          wcnt_d  = 8'h00;
        end
      endcase
    end
    size_err = size_chk && (size_wcnt != lfsr_q);
  end

  always_comb begin
    lfsr_d = lfsr_q;
    if (size_chk) begin
`ifdef RIO_PKT_CHK_RESYNC_EN
      lfsr_d = size_err ? lfsr_step(size_wcnt) : lfsr_step(lfsr_q);
`else
      lfsr_d = lfsr_step(lfsr_q);
`endif
    end
  end

  // Expected-data counter runs across packets; resync reloads it from a mismatching word.
  always_comb begin
    data_err = beat && (i_rx_data != dcnt_q);
    dcnt_d   = dcnt_q;
    if (beat) begin
`ifdef RIO_PKT_CHK_RESYNC_EN
      dcnt_d = data_err ? (i_rx_data + DATA_ONE) : (dcnt_q + DATA_ONE);
`else
      dcnt_d = dcnt_q + DATA_ONE;
`endif
    end
  end

  always_comb begin
    data_err_cnt_d  = sat_inc(data_err_cnt_q, data_err);
    size_err_cnt_d  = sat_inc(size_err_cnt_q, size_err);
    frame_err_cnt_d = sat_inc(frame_err_cnt_q, frame_err);
    pkt_cnt_d       = sat_inc(pkt_cnt_q, eop);
    data_flag_d     = data_flag_q | data_err;
    size_flag_d     = size_flag_q | size_err;
    frame_flag_d    = frame_flag_q | frame_err;
  end

  // Synchronous clear wins over any event arriving in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      lfsr_q          <= LFSR_SEED;
      wcnt_q          <= 8'h00;
      dcnt_q          <= DATA_SEED;
      data_err_cnt_q  <= '0;
      size_err_cnt_q  <= '0;
      frame_err_cnt_q <= '0;
      pkt_cnt_q       <= '0;
      data_flag_q     <= 1'b0;
      size_flag_q     <= 1'b0;
      frame_flag_q    <= 1'b0;
    end else if (i_clr) begin
      state_q         <= IDLE;
      lfsr_q          <= LFSR_SEED;
      wcnt_q          <= 8'h00;
      dcnt_q          <= DATA_SEED;
      data_err_cnt_q  <= '0;
      size_err_cnt_q  <= '0;
      frame_err_cnt_q <= '0;
      pkt_cnt_q       <= '0;
      data_flag_q     <= 1'b0;
      size_flag_q     <= 1'b0;
      frame_flag_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      lfsr_q          <= lfsr_d;
      wcnt_q          <= wcnt_d;
      dcnt_q          <= dcnt_d;
      data_err_cnt_q  <= data_err_cnt_d;
      size_err_cnt_q  <= size_err_cnt_d;
      frame_err_cnt_q <= frame_err_cnt_d;
      pkt_cnt_q       <= pkt_cnt_d;
      data_flag_q     <= data_flag_d;
      size_flag_q     <= size_flag_d;
      frame_flag_q    <= frame_flag_d;
    end
  end

  assign o_data_err_cnt   = data_err_cnt_q;
  assign o_size_err_cnt   = size_err_cnt_q;
  assign o_frame_err_cnt  = frame_err_cnt_q;
  assign o_pkt_cnt        = pkt_cnt_q;
  assign o_rx_data_error  = data_flag_q;
  assign o_rx_size_error  = size_flag_q;
  assign o_rx_frame_error = frame_flag_q;

endmodule

// File: tb/tb_rio_packet_checker.sv
// Bench for rio_packet_checker: packet-level vector table with a scoreboard queue, plus
// hand-written framing, saturation, clear and async-reset sequences.
`timescale 1ns/1ps
module tb_rio_packet_checker;

  localparam int DW  = 16;
  localparam int CW  = 20;
  localparam int SCW = 4;

`ifdef RIO_PKT_CHK_RESYNC_EN
  localparam int BAD_DATA_ERRS = 2;
  localparam int SECOND_LEN    = 9;
`else
  localparam int BAD_DATA_ERRS = 1;
  localparam int SECOND_LEN    = 11;
`endif

  logic          clk;
  logic          rst;
  logic          i_clr;
  logic          i_rx_valid;
  logic          i_rx_sop;
  logic          i_rx_eop;
  logic [DW-1:0] i_rx_data;

  logic [CW-1:0] data_err_cnt, size_err_cnt, frame_err_cnt, pkt_cnt;
  logic          data_flag, size_flag, frame_flag;
  logic [SCW-1:0] s_data_err_cnt, s_size_err_cnt, s_frame_err_cnt, s_pkt_cnt;
  logic           s_data_flag, s_size_flag, s_frame_flag;

  int checks = 0;
  int passed = 0;

  typedef struct {
    bit          rst_before;
    string       name;
    int          nbeats;
    int          bad_beat;
    logic [DW-1:0] bad_val;
    int          exp_data;
    int          exp_size;
    int          exp_frame;
    int          exp_pkt;
  } pkt_vec_t;

  typedef struct {
    string name;
    int    data;
    int    size;
    int    frame;
    int    pkt;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] next_data;
  pkt_vec_t      vecs[7];

  rio_packet_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .i_clr(i_clr),
    .i_rx_valid(i_rx_valid), .i_rx_sop(i_rx_sop), .i_rx_eop(i_rx_eop), .i_rx_data(i_rx_data),
    .o_data_err_cnt(data_err_cnt), .o_size_err_cnt(size_err_cnt),
    .o_frame_err_cnt(frame_err_cnt), .o_pkt_cnt(pkt_cnt),
    .o_rx_data_error(data_flag), .o_rx_size_error(size_flag), .o_rx_frame_error(frame_flag)
  );

  rio_packet_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(SCW)) dut_sat (
    .clk(clk), .rst(rst), .i_clr(i_clr),
    .i_rx_valid(i_rx_valid), .i_rx_sop(i_rx_sop), .i_rx_eop(i_rx_eop), .i_rx_data(i_rx_data),
    .o_data_err_cnt(s_data_err_cnt), .o_size_err_cnt(s_size_err_cnt),
    .o_frame_err_cnt(s_frame_err_cnt), .o_pkt_cnt(s_pkt_cnt),
    .o_rx_data_error(s_data_flag), .o_rx_size_error(s_size_flag), .o_rx_frame_error(s_frame_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkField(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", n, act, exp);
  endtask

  task automatic pushExpected(input string n, input int d, input int s, input int f, input int p);
    exp_t e;
    e.name  = n;
    e.data  = d;
    e.size  = s;
    e.frame = f;
    e.pkt   = p;
    sb_q.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    e = sb_q.pop_front();
    checkField({e.name, ".data_err_cnt"},  64'(data_err_cnt),  64'(e.data));
    checkField({e.name, ".size_err_cnt"},  64'(size_err_cnt),  64'(e.size));
    checkField({e.name, ".frame_err_cnt"}, 64'(frame_err_cnt), 64'(e.frame));
    checkField({e.name, ".pkt_cnt"},       64'(pkt_cnt),       64'(e.pkt));
    checkField({e.name, ".data_flag"},     64'(data_flag),     64'(e.data != 0));
    checkField({e.name, ".size_flag"},     64'(size_flag),     64'(e.size != 0));
    checkField({e.name, ".frame_flag"},    64'(frame_flag),    64'(e.frame != 0));
  endtask

  task automatic sendBeat(input logic sop, input logic eop, input logic [DW-1:0] data);
    i_rx_valid = 1'b1;
    i_rx_sop   = sop;
    i_rx_eop   = eop;
    i_rx_data  = data;
    @(posedge clk);
    #1;
    i_rx_valid = 1'b0;
    i_rx_sop   = 1'b0;
    i_rx_eop   = 1'b0;
  endtask

  task automatic doReset();
    rst        = 1'b1;
    i_clr      = 1'b0;
    i_rx_valid = 1'b0;
    i_rx_sop   = 1'b0;
    i_rx_eop   = 1'b0;
    i_rx_data  = '0;
    next_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input pkt_vec_t v);
    logic [DW-1:0] d;
    pushExpected(v.name, v.exp_data, v.exp_size, v.exp_frame, v.exp_pkt);
    for (int b = 0; b < v.nbeats; b++) begin
      d = (b == v.bad_beat) ? v.bad_val : next_data;
      sendBeat(b == 0, b == v.nbeats - 1, d);
      next_data = next_data + 16'd1;
    end
  endtask

  initial begin
    // LFSR from seed 5: expected lengths 6, 11, ... ; a 1-beat packet never matches a nonzero LFSR.
    vecs[0] = '{1'b1, "clean6",      6,  -1, 16'h0000, 0,             0, 0, 1};
    vecs[1] = '{1'b0, "clean11",     11, -1, 16'h0000, 0,             0, 0, 2};
    vecs[2] = '{1'b1, "bad6",        6,  3,  16'hDEAD, BAD_DATA_ERRS, 0, 0, 1};
    vecs[3] = '{1'b0, "after_bad11", 11, -1, 16'h0000, BAD_DATA_ERRS, 0, 0, 2};
    vecs[4] = '{1'b1, "short5",      5,  -1, 16'h0000, 0,             1, 0, 1};
    vecs[5] = '{1'b0, "second_len",  SECOND_LEN, -1, 16'h0000, 0,     1, 0, 2};
    vecs[6] = '{1'b1, "one_beat",    1,  -1, 16'h0000, 0,             1, 0, 1};

    doReset();
    pushExpected("reset", 0, 0, 0, 0);
    checkOutput();

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].rst_before) doReset();
      applyStimulus(vecs[i]);
      checkOutput();
    end

    // Stray beat in IDLE, then a sop inside DATA restarting a 6-beat packet.
    doReset();
    pushExpected("stray_beat", 0, 0, 1, 0);
    sendBeat(1'b0, 1'b0, 16'd0);
    checkOutput();
    pushExpected("restart_pkt", 0, 0, 2, 1);
    sendBeat(1'b1, 1'b0, 16'd1);
    sendBeat(1'b0, 1'b0, 16'd2);
    sendBeat(1'b0, 1'b0, 16'd3);
    sendBeat(1'b1, 1'b0, 16'd4);
    for (int k = 5; k <= 8; k++) sendBeat(1'b0, 1'b0, 16'(k));
    sendBeat(1'b0, 1'b1, 16'd9);
    checkOutput();

    // 19 bad IDLE beats: 20-bit counters count all, 4-bit counters hold at 15.
    doReset();
    pushExpected("saturate", 19, 0, 19, 0);
    for (int k = 0; k < 19; k++) sendBeat(1'b0, 1'b0, 16'hFFFF);
    checkOutput();
    checkField("sat.data_err_cnt",  64'(s_data_err_cnt),  64'd15);
    checkField("sat.frame_err_cnt", 64'(s_frame_err_cnt), 64'd15);
    checkField("sat.size_err_cnt",  64'(s_size_err_cnt),  64'd0);
    checkField("sat.data_flag",     64'(s_data_flag),     64'd1);

    pushExpected("clear_with_err", 0, 0, 0, 0);
    i_clr = 1'b1;
    sendBeat(1'b0, 1'b0, 16'hFFFF);
    i_clr = 1'b0;
    checkOutput();
    checkField("sat_clr.data_err_cnt",  64'(s_data_err_cnt),  64'd0);
    checkField("sat_clr.frame_err_cnt", 64'(s_frame_err_cnt), 64'd0);
    checkField("sat_clr.data_flag",     64'(s_data_flag),     64'd0);
    checkField("sat_clr.frame_flag",    64'(s_frame_flag),    64'd0);

    // Async reset mid-packet, off the clock edge.
    doReset();
    pushExpected("pre_async_rst", BAD_DATA_ERRS, 0, 0, 0);
    sendBeat(1'b1, 1'b0, 16'hBEEF);
    sendBeat(1'b0, 1'b0, 16'd1);
    checkOutput();
    #2;
    rst = 1'b1;
    #1;
    pushExpected("async_rst", 0, 0, 0, 0);
    checkOutput();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    next_data = '0;
    applyStimulus('{1'b0, "post_rst6", 6, -1, 16'h0000, 0, 0, 0, 1});
    checkOutput();

    checkField("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
